// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter sharing a single memory bus between the CPU (port 0)
// and the loader/debug DMA (port 1), with a fixed memory read latency.
module mem_arbiter #(
  parameter int AW      = 32,
  parameter int DW      = 32,
  parameter int MEM_LAT = 1
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          r0_req,
  input  logic          r0_rw,
  input  logic [AW-1:0] r0_addr,
  input  logic [DW-1:0] r0_wdata,
  output logic          r0_ack,
  output logic [DW-1:0] r0_rdata,
  input  logic          r1_req,
  input  logic          r1_rw,
  input  logic [AW-1:0] r1_addr,
  input  logic [DW-1:0] r1_wdata,
  output logic          r1_ack,
  output logic [DW-1:0] r1_rdata,
  output logic          mem_en,
  output logic          mem_rw,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_wdata,
  input  logic [DW-1:0] mem_rdata,
  output logic          busy,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, ACK} state_t;

  localparam logic [3:0] LAT_LOAD = 4'(MEM_LAT - 1);

  state_t     state;
  logic       last;
  logic [3:0] wait_cnt;
  logic       gnt;

  function automatic logic [3:0] dec_sat(input logic [3:0] c);
    return (c == 4'd0) ? 4'd0 : c - 4'd1;
  endfunction

  // On a tie the port that did not win last time goes first.
  function automatic logic pick_port(input logic q0, input logic q1, input logic lst);
    if (q0 && q1) return ~lst;
    return q1;
  endfunction

  assign gnt = pick_port(r0_req, r1_req, last);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state     <= IDLE;
      last      <= 1'b1;
      owner     <= 1'b0;
      busy      <= 1'b0;
      mem_en    <= 1'b0;
      mem_rw    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      wait_cnt  <= '0;
      r0_ack    <= 1'b0;
      r1_ack    <= 1'b0;
      r0_rdata  <= '0;
      r1_rdata  <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (r0_req || r1_req) begin
            owner     <= gnt;
            last      <= gnt;
            mem_rw    <= gnt ? r1_rw    : r0_rw;
            mem_addr  <= gnt ? r1_addr  : r0_addr;
            mem_wdata <= gnt ? r1_wdata : r0_wdata;
            mem_en    <= 1'b1;
            busy      <= 1'b1;
            state     <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en <= 1'b0;
          if (mem_rw) begin
            wait_cnt <= LAT_LOAD;
            state    <= WAIT;
          end else begin
            r0_ack <= ~owner;
            r1_ack <= owner;
            state  <= ACK;
          end
        end
        WAIT: begin
          if (wait_cnt == 4'd0) begin
            if (owner) r1_rdata <= mem_rdata;
            else       r0_rdata <= mem_rdata;
            r0_ack <= ~owner;
            r1_ack <= owner;
            state  <= ACK;
          end else begin
            wait_cnt <= dec_sat(wait_cnt);
          end
        end
        ACK: begin
          // Always return to IDLE so requesters can drop req before re-arbitration.
          r0_ack <= 1'b0;
          r1_ack <= 1'b0;
          busy   <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized run against a transaction-timing reference model.
`timescale 1ns/1ps
module tb_mem_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int LAT = 3;
  localparam int NRAND = 1500;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic          r0_req = 1'b0, r0_rw = 1'b0, r1_req = 1'b0, r1_rw = 1'b0;
  logic [31:0]   r0_addr = '0, r0_wdata = '0, r1_addr = '0, r1_wdata = '0;
  logic          r0_ack, r1_ack, mem_en, mem_rw, busy, owner;
  logic [31:0]   r0_rdata, r1_rdata, mem_addr, mem_wdata, mem_rdata;

  int n_tests = 0;
  int n_fail = 0;

  logic [31:0] mem [256];
  logic        pv [LAT] = '{default: 1'b0};
  logic [31:0] pd [LAT] = '{default: 32'h0};

  mem_arbiter #(.AW(AW), .DW(DW), .MEM_LAT(LAT)) dut (
    .clk(clk), .reset(reset),
    .r0_req(r0_req), .r0_rw(r0_rw), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_ack(r0_ack), .r0_rdata(r0_rdata),
    .r1_req(r1_req), .r1_rw(r1_rw), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_ack(r1_ack), .r1_rdata(r1_rdata),
    .mem_en(mem_en), .mem_rw(mem_rw), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .busy(busy), .owner(owner)
  );

  always #5 clk = ~clk;

  // Memory: read data is valid only in the cycle exactly LAT cycles after the issue cycle.
  always @(posedge clk) begin
    pv[0] <= mem_en && mem_rw;
    pd[0] <= mem[mem_addr[7:0]];
    for (int i = 1; i < LAT; i++) begin
      pv[i] <= pv[i-1];
      pd[i] <= pd[i-1];
    end
  end
  assign mem_rdata = pv[LAT-1] ? pd[LAT-1] : 32'h0BAD_F00D;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic got, input logic exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b, expected %b (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic chki(input string name, input int got, input int exp);
    n_tests++;
    if (got != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, got, exp, $time);
    end
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit p, input logic rq, input logic rw,
                       input logic [31:0] a, input logic [31:0] w);
    if (p) begin r1_req = rq; r1_rw = rw; r1_addr = a; r1_wdata = w; end
    else   begin r0_req = rq; r0_rw = rw; r0_addr = a; r0_wdata = w; end
  endtask

  task automatic do_reset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
  endtask

  // Runs one transaction from cycle 0 (the call time) and drops req in the cycle after ack.
  task automatic run_txn(input bit p, input bit rw, input logic [31:0] a, input logic [31:0] w,
                         input int chg_cyc, input logic [31:0] chg_a,
                         output int ack_cyc, output int en_cyc, output int en_cnt,
                         output logic en_rw, output logic [31:0] en_a, output logic [31:0] en_w,
                         output bit a_stable, output int other_acks,
                         output logic [31:0] rd0, output logic [31:0] rd1);
    ack_cyc = -1; en_cyc = -1; en_cnt = 0; a_stable = 1'b1; other_acks = 0;
    en_rw = 1'b0; en_a = '0; en_w = '0; rd0 = '0; rd1 = '0;
    drive(p, 1'b1, rw, a, w);
    for (int k = 0; k <= 25; k++) begin
      if (k == chg_cyc) drive(p, 1'b1, rw, chg_a, w);
      @(negedge clk);
      if (mem_en) begin
        en_cnt++;
        if (en_cyc < 0) begin
          en_cyc = k; en_rw = mem_rw; en_a = mem_addr; en_w = mem_wdata;
        end
      end
      if (en_cyc >= 0 && mem_addr !== en_a) a_stable = 1'b0;
      if (p ? r0_ack : r1_ack) other_acks++;
      if (p ? r1_ack : r0_ack) begin
        ack_cyc = k; rd0 = r0_rdata; rd1 = r1_rdata;
        break;
      end
      next_cycle();
    end
    next_cycle();
    drive(p, 1'b0, rw, a, w);
  endtask

  typedef struct {
    bit          port;
    bit          rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [31:0] memval;
    int          chg_cyc;
    logic [31:0] chg_addr;
    int          exp_ack;
    logic [31:0] exp_r0;
    logic [31:0] exp_r1;
  } vec_t;

  vec_t vecs [7];

  initial begin
    int ack_cyc, en_cyc, en_cnt, other_acks, n_en;
    logic en_rw;
    logic [31:0] en_a, en_w, rd0, rd1;
    bit a_stable;
    int owners [4];
    int en_t [4];
    // reference model state for the randomized run
    int free_at, iss_t, ack_t;
    bit last_m, own_m, rw_m, g;
    logic [31:0] addr_m, wd_m, exp_addr, exp_wd;
    logic [31:0] exp_rd [2];
    bit act [2];
    bit granted_q [2];
    bit rw_q [2];
    logic [31:0] a_q [2];
    logic [31:0] w_q [2];

    for (int i = 0; i < 256; i++)
      mem[i] = {i[7:0], ~i[7:0], i[7:0] ^ 8'h5A, 8'hC3};

    vecs[0] = '{1'b0, 1'b1, 32'h10, 32'h1111, 32'hDEADBEEF, -1, 32'h0, 2+LAT, 32'hDEADBEEF, 32'h0};
    vecs[1] = '{1'b1, 1'b0, 32'h20, 32'h55, 32'h0, -1, 32'h0, 2, 32'hDEADBEEF, 32'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h10, 32'h2222, 32'hDEADBEEF, 1, 32'h99, 2+LAT, 32'hDEADBEEF, 32'h0};
    vecs[3] = '{1'b1, 1'b1, 32'h44, 32'h0, 32'hCAFEF00D, -1, 32'h0, 2+LAT, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[4] = '{1'b0, 1'b0, 32'hFFFFFF00, 32'hA5A5A5A5, 32'h0, -1, 32'h0, 2, 32'hDEADBEEF, 32'hCAFEF00D};
    vecs[5] = '{1'b1, 1'b1, 32'h3, 32'hFFFFFFFF, 32'h12345678, -1, 32'h0, 2+LAT, 32'hDEADBEEF, 32'h12345678};
    vecs[6] = '{1'b0, 1'b1, 32'h10, 32'h0, 32'h00000001, -1, 32'h0, 2+LAT, 32'h00000001, 32'h12345678};

    // Reset held with both requests high: every output stays 0.
    drive(1'b0, 1'b1, 1'b1, 32'h30, 32'h0);
    drive(1'b1, 1'b1, 1'b0, 32'h40, 32'h77);
    repeat (3) begin
      @(negedge clk);
      chk1("rst_mem_en", mem_en, 1'b0);
      chk1("rst_mem_rw", mem_rw, 1'b0);
      chk1("rst_busy", busy, 1'b0);
      chk1("rst_owner", owner, 1'b0);
      chk1("rst_r0_ack", r0_ack, 1'b0);
      chk1("rst_r1_ack", r1_ack, 1'b0);
      chk("rst_mem_addr", mem_addr, 32'h0);
      chk("rst_mem_wdata", mem_wdata, 32'h0);
      chk("rst_r0_rdata", r0_rdata, 32'h0);
      chk("rst_r1_rdata", r1_rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(negedge clk);
    chk1("rel_c0_mem_en", mem_en, 1'b0);
    next_cycle();
    @(negedge clk);
    chk1("rel_c1_mem_en", mem_en, 1'b1);
    chk1("rel_c1_owner", owner, 1'b0);
    chk("rel_c1_mem_addr", mem_addr, 32'h30);
    chk1("rel_c1_mem_rw", mem_rw, 1'b1);
    next_cycle();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
    do_reset();

    // Directed vector table.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].rw) mem[vecs[i].addr[7:0]] = vecs[i].memval;
      run_txn(vecs[i].port, vecs[i].rw, vecs[i].addr, vecs[i].wdata, vecs[i].chg_cyc,
              vecs[i].chg_addr, ack_cyc, en_cyc, en_cnt, en_rw, en_a, en_w, a_stable,
              other_acks, rd0, rd1);
      chki($sformatf("v%0d_ack_cycle", i), ack_cyc, vecs[i].exp_ack);
      chki($sformatf("v%0d_en_cycle", i), en_cyc, 1);
      chki($sformatf("v%0d_en_count", i), en_cnt, 1);
      chk1($sformatf("v%0d_mem_rw", i), en_rw, vecs[i].rw);
      chk($sformatf("v%0d_mem_addr", i), en_a, vecs[i].addr);
      chk($sformatf("v%0d_mem_wdata", i), en_w, vecs[i].wdata);
      chk1($sformatf("v%0d_addr_stable", i), a_stable, 1'b1);
      chki($sformatf("v%0d_other_acks", i), other_acks, 0);
      chk($sformatf("v%0d_r0_rdata", i), rd0, vecs[i].exp_r0);
      chk($sformatf("v%0d_r1_rdata", i), rd1, vecs[i].exp_r1);
      @(negedge clk);
      chk1($sformatf("v%0d_idle_busy", i), busy, 1'b0);
      chk1($sformatf("v%0d_idle_mem_en", i), mem_en, 1'b0);
      chk($sformatf("v%0d_held_r0", i), r0_rdata, vecs[i].exp_r0);
      chk($sformatf("v%0d_held_r1", i), r1_rdata, vecs[i].exp_r1);
      next_cycle();
    end

    // Both ports reading back-to-back: strict alternation, one grant per LAT+3 cycles.
    do_reset();
    drive(1'b0, 1'b1, 1'b1, 32'h60, 32'h0);
    drive(1'b1, 1'b1, 1'b1, 32'h61, 32'h0);
    n_en = 0;
    for (int k = 0; k < 80 && n_en < 4; k++) begin
      @(negedge clk);
      if (mem_en) begin
        owners[n_en] = int'(owner);
        en_t[n_en] = k;
        n_en++;
      end
      if (n_en < 4) next_cycle();
    end
    chki("rr_grant_count", n_en, 4);
    chki("rr_owner0", owners[0], 0);
    chki("rr_owner1", owners[1], 1);
    chki("rr_owner2", owners[2], 0);
    chki("rr_owner3", owners[3], 1);
    chki("rr_gap01", en_t[1] - en_t[0], LAT + 3);
    chki("rr_gap12", en_t[2] - en_t[1], LAT + 3);
    chk("rr_r0_rdata", r0_rdata, mem[8'h60]);
    chk("rr_r1_rdata", r1_rdata, mem[8'h61]);
    next_cycle();
    drive(1'b0, 1'b0, 1'b1, 32'h0, 32'h0);
    drive(1'b1, 1'b0, 1'b1, 32'h0, 32'h0);

    // Reset pulled mid-WAIT aborts; the still-high request then completes normally.
    do_reset();
    mem[8'h50] = 32'h5A5A0001;
    drive(1'b0, 1'b1, 1'b1, 32'h50, 32'h0);
    next_cycle();
    next_cycle();
    #2;
    reset = 1'b0;
    #1;
    chk1("midwait_busy_now", busy, 1'b0);
    chk1("midwait_ack_now", r0_ack, 1'b0);
    chk1("midwait_owner_now", owner, 1'b0);
    repeat (3) begin
      @(negedge clk);
      chk1("midwait_no_ack", r0_ack, 1'b0);
      chk1("midwait_no_en", mem_en, 1'b0);
      chk("midwait_rdata", r0_rdata, 32'h0);
    end
    @(posedge clk);
    #1;
    reset = 1'b1;
    run_txn(1'b0, 1'b1, 32'h50, 32'h0, -1, 32'h0, ack_cyc, en_cyc, en_cnt, en_rw, en_a, en_w,
            a_stable, other_acks, rd0, rd1);
    chki("postrst_ack_cycle", ack_cyc, 2 + LAT);
    chki("postrst_en_count", en_cnt, 1);
    chk("postrst_rdata", rd0, 32'h5A5A0001);

    // Randomized traffic against the timing model.
    do_reset();
    free_at = 0; iss_t = -100; ack_t = -100; last_m = 1'b1; own_m = 1'b0; rw_m = 1'b0;
    addr_m = '0; wd_m = '0; exp_addr = '0; exp_wd = '0;
    exp_rd[0] = '0; exp_rd[1] = '0;
    for (int p = 0; p < 2; p++) begin
      act[p] = 1'b0; granted_q[p] = 1'b0; rw_q[p] = 1'b0; a_q[p] = '0; w_q[p] = '0;
    end
    for (int t = 0; t < NRAND; t++) begin
      for (int p = 0; p < 2; p++) begin
        if (!act[p]) begin
          if ($urandom_range(0, 2) == 0) begin
            act[p] = 1'b1;
            rw_q[p] = 1'($urandom_range(0, 1));
            a_q[p] = $urandom;
            w_q[p] = $urandom;
          end
        end else if (granted_q[p]) begin
          rw_q[p] = 1'($urandom_range(0, 1));
          a_q[p] = $urandom;
          w_q[p] = $urandom;
        end
        drive(1'(p), act[p], rw_q[p], a_q[p], w_q[p]);
      end
      if (t >= free_at && (act[0] || act[1])) begin
        g = (act[0] && act[1]) ? ~last_m : act[1];
        last_m = g; own_m = g; rw_m = rw_q[g]; addr_m = a_q[g]; wd_m = w_q[g];
        granted_q[g] = 1'b1;
        iss_t = t + 1;
        ack_t = rw_m ? t + 2 + LAT : t + 2;
        free_at = ack_t + 1;
      end
      @(negedge clk);
      if (t == iss_t) begin exp_addr = addr_m; exp_wd = wd_m; end
      if (t == ack_t && rw_m) exp_rd[own_m] = mem[addr_m[7:0]];
      chk1("rnd_mem_en", mem_en, t == iss_t);
      if (t == iss_t) chk1("rnd_mem_rw", mem_rw, rw_m);
      chk("rnd_mem_addr", mem_addr, exp_addr);
      chk("rnd_mem_wdata", mem_wdata, exp_wd);
      chk1("rnd_busy", busy, t >= iss_t && t <= ack_t);
      if (t >= iss_t && t <= ack_t) chk1("rnd_owner", owner, own_m);
      chk1("rnd_r0_ack", r0_ack, t == ack_t && own_m == 1'b0);
      chk1("rnd_r1_ack", r1_ack, t == ack_t && own_m == 1'b1);
      chk("rnd_r0_rdata", r0_rdata, exp_rd[0]);
      chk("rnd_r1_rdata", r1_rdata, exp_rd[1]);
      if (t == ack_t) begin
        act[own_m] = 1'b0;
        granted_q[own_m] = 1'b0;
      end
      next_cycle();
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Two-port memory arbiter that shares the CPU's single 32-bit memory bus between two requesters.
- Port 0 is the CPU fetch/execute side.
- Port 1 is the program loader / debug DMA side.
- Each port uses a req/ack handshake. The arbiter serialises transactions with round-robin priority and enforces a fixed memory read latency.
- It sits between the requesters and the memory, and is the only driver of the memory address, write-data and control lines.

## Interface
Parameters:
- AW, 32, address width.
- DW, 32, data width.
- MEM_LAT, 1, cycles from the issue cycle to valid read data on mem_rdata. Legal range 1..15.

Ports:
- clk  in  1  single system clock; all state changes on the rising edge.
- reset  in  1  asynchronous, active-low reset.
- r0_req  in  1  port 0 request; held high until r0_ack.
- r0_rw  in  1  port 0 direction: 1 = read, 0 = write.
- r0_addr  in  AW  port 0 address.
- r0_wdata  in  DW  port 0 write data.
- r0_ack  out  1  one-cycle completion pulse for port 0.
- r0_rdata  out  DW  port 0 read data; valid in the r0_ack cycle; held until the next port 0 read completes.
- r1_req, r1_rw, r1_addr, r1_wdata, r1_ack, r1_rdata: same as the r0_* ports, for port 1.
- mem_en  out  1  memory strobe; high for exactly one cycle per transaction.
- mem_rw  out  1  1 = read, 0 = write; valid while mem_en is high.
- mem_addr  out  AW  memory address.
- mem_wdata  out  DW  memory write data.
- mem_rdata  in  DW  memory read data.
- busy  out  1  high whenever state is not IDLE.
- owner  out  1  index of the granted port; meaningful only while busy.

## Operation
States are IDLE, ISSUE, WAIT and ACK.

IDLE:
- If no request is present, stay in IDLE.
- If exactly one req is high, grant that port.
- If both reqs are high, grant the port that is not `last`. `last` resets to 1, so port 0 wins the first tie.
- On a grant:
  - latch owner, rw, addr and wdata from the granted port;
  - set `last` to the granted port;
  - go to ISSUE.

ISSUE:
- Drive mem_en = 1 with mem_rw, mem_addr and mem_wdata taken from the latched values.
- Write: go to ACK.
- Read: load the wait counter with MEM_LAT-1 and go to WAIT.

WAIT:
- While the counter is nonzero, decrement it.
- When the counter is 0, capture mem_rdata into the owner's rdata register and go to ACK.

ACK:
- Pulse the owner's ack for one cycle, then go to IDLE unconditionally.
- The mandatory return to IDLE is the only bubble between transactions. It lets the requester drop req before the next arbitration.

Requester rules:
- A port whose req is still high in IDLE after its ack is treated as a new request.
- The arbiter samples the requester's fields only at grant. Changing r*_addr, r*_rw or r*_wdata after grant has no effect.
- A port that is not granted sees no change on its ack or rdata outputs.

Other rules:
- The wait counter is 4 bits wide and never underflows.
- The non-owner's rdata is never written.
- mem_addr and mem_wdata hold their last latched value when mem_en is low.

## Timing
- Reset (reset low, asynchronous): the following take effect immediately, without waiting for a clock edge.
  - State goes to IDLE.
  - mem_en, mem_rw, r0_ack, r1_ack, busy and owner go to 0.
  - mem_addr, mem_wdata, r0_rdata, r1_rdata and the counter go to 0.
  - `last` goes to 1.
- Reset asserted mid-transaction aborts the transaction. No ack is produced, and nothing is re-issued after reset releases.
- Read latency: req seen in IDLE at cycle 0; ISSUE at cycle 1; capture at cycle 1+MEM_LAT; ack at cycle 2+MEM_LAT.
- Write latency: req at cycle 0; ISSUE (mem_en) at cycle 1; ack at cycle 2.
- Throughput: one transaction per 3 cycles for writes and per MEM_LAT+3 cycles for reads.
- A request arriving while busy waits. It is arbitrated in the next IDLE cycle.
- Requests rising in the same cycle count as simultaneous and are resolved by `last`.
- All outputs are registered or decoded from state. There is no combinational path from any req to mem_en.

## Test plan
- Reset values: hold reset low for 3 cycles with both reqs high, then release.
  - During reset: all outputs 0 and no mem_en.
  - After release: port 0 is granted, with mem_en on the 2nd edge.
- Single read, MEM_LAT=2: r0 reads addr 0x10 and memory returns 0xDEADBEEF.
  - mem_en with mem_rw=1 and mem_addr=0x10 at cycle 1.
  - r0_ack at cycle 4 with r0_rdata=0xDEADBEEF.
  - r1_rdata stays 0.
- Write: r1 writes 0x55 to addr 0x20.
  - Exactly one mem_en cycle with mem_rw=0, mem_addr=0x20, mem_wdata=0x55.
  - r1_ack two cycles after req.
- Simultaneous requests: both ports read continuously (each re-asserts req after its ack).
  - Grant order is 0,1,0,1.
  - owner toggles on each ISSUE and no port is starved.
- Reset mid-WAIT (MEM_LAT=3): pull reset low during WAIT.
  - busy drops immediately and no ack is produced.
  - After release, the reasserted req completes with normal latency.
- Field change after grant: change r0_addr from 0x10 to 0x99 in the ISSUE cycle.
  - mem_addr stays 0x10 throughout.
